// File: rtl/load_seq_pkg.sv
// Shared types for the load sequencer: FSM state encoding and the queued command.
// Hold fields are stored at HOLD_MAX_W bits so one struct serves any HOLD_W <= HOLD_MAX_W.
// No logic; imported by ldseq_fifo and load_sequencer.
package load_seq_pkg;

    // Width of the downstream counter's load value.
    localparam int CNT_W      = 4;
    // Widest supported hold-off count; narrower HOLD_W values are zero-extended.
    localparam int HOLD_MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } ldseq_state_t;

    typedef struct packed {
        logic [CNT_W-1:0]      value;
        logic [HOLD_MAX_W-1:0] hold;
    } ldseq_cmd_t;

endpackage

// File: rtl/ldseq_fifo.sv
// Synchronous command FIFO for the load sequencer (DEPTH entries, power of two, >= 2).
// Ports: push/wr_data in, pop/rd_data out (rd_data is the head, valid while !empty),
//        full/empty flags and level; async active-high reset empties it.
// Pointers wrap modulo DEPTH; a separate level count keeps full/empty unambiguous.
module ldseq_fifo
    import load_seq_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  ldseq_cmd_t    wr_data,
    input  logic          pop,
    output ldseq_cmd_t    rd_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    ldseq_cmd_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // Overflow/underflow requests are ignored rather than corrupting state.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);

endmodule

// File: rtl/load_sequencer.sv
// Load sequencer: queues {value, hold} commands and replays each as a one-cycle
// registered ld/ldvalue pulse to the 4-bit loadable counter, followed by exactly
// `hold` idle cycles before the next pulse. Command accepted on edge k with the
// block idle gives ld=1 between edges k+1 and k+2 (no bypass).
// Ports: clk, reset (async, active high); cmd_valid/cmd_ready/cmd_value/cmd_hold
// command handshake (cmd_ready = !full); ld/ldvalue to the counter; busy; fifo_level.
// Optional macro LDSEQ_REPEAT_EN adds input repeat_en: when set and the queue is
// empty, the last command is reissued periodically instead of going idle. The port
// is not called `repeat` because that word is a reserved SystemVerilog keyword.
// HOLD_W must not exceed load_seq_pkg::HOLD_MAX_W.
module load_sequencer
    import load_seq_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int HOLD_W = 8,
    localparam int LW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CNT_W-1:0]  cmd_value,
    input  logic [HOLD_W-1:0] cmd_hold,
`ifdef LDSEQ_REPEAT_EN
    input  logic              repeat_en,
`endif
    output logic              ld,
    output logic [CNT_W-1:0]  ldvalue,
    output logic              busy,
    output logic [LW-1:0]     fifo_level
);

    localparam logic [HOLD_MAX_W-1:0] HOLD_ONE = HOLD_MAX_W'(1);

    ldseq_state_t          state;
    ldseq_state_t          state_nxt;
    logic [HOLD_MAX_W-1:0] hold_lat;   // hold of the most recently issued command
    logic [HOLD_MAX_W-1:0] hold_cnt;
    logic [HOLD_MAX_W-1:0] cnt_nxt;
    logic                  pop;
    logic                  push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  rpt;
    ldseq_cmd_t            wr_cmd;
    ldseq_cmd_t            head;

`ifdef LDSEQ_REPEAT_EN
    assign rpt = repeat_en;
`else
    assign rpt = 1'b0;
`endif

    assign cmd_ready    = !fifo_full;
    assign push         = cmd_valid && cmd_ready;
    assign wr_cmd.value = cmd_value;
    assign wr_cmd.hold  = HOLD_MAX_W'(cmd_hold);

    ldseq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (wr_cmd),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Next state. Every entry into LOAD either pops the FIFO head or, when
    // repeating, reuses the latched value/hold (which are simply left alone).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = hold_cnt;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = LOAD;
                    pop       = 1'b1;
                end
            end
            LOAD: begin
                if (hold_lat != '0) begin
                    // Counter runs hold-1 .. 0, giving exactly `hold` ld=0 cycles.
                    state_nxt = HOLD;
                    cnt_nxt   = hold_lat - HOLD_ONE;
                end else if (!fifo_empty) begin
                    state_nxt = LOAD;
                    pop       = 1'b1;
                end else if (rpt) begin
                    state_nxt = LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (hold_cnt != '0) begin
                    cnt_nxt = hold_cnt - HOLD_ONE;
                end else if (!fifo_empty) begin
                    state_nxt = LOAD;
                    pop       = 1'b1;
                end else if (rpt) begin
                    state_nxt = LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            hold_lat <= '0;
            ld       <= 1'b0;
            ldvalue  <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= cnt_nxt;
            ld       <= (state_nxt == LOAD);
            if (pop) begin
                ldvalue  <= head.value;
                hold_lat <= head.hold;
            end
        end
    end

    assign busy = !fifo_empty || (state != IDLE);

endmodule
